// File: rtl/xrv1_pkg.sv
// Shared xrv1 types and constants: the data-memory request bundle carried
// between requesters, the dmem arbiter and the memory/bus port.
package xrv1_pkg;

  localparam int DMEM_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        w_en;
    logic [3:0]  w_be;
    logic [31:0] w_data;
  } dmem_req_t;

endpackage

// File: rtl/xrv1_id_fifo.sv
// Small synchronous FIFO with occupancy count; push is ignored when full
// and pop is ignored when empty, so callers may strobe them freely.
module xrv1_id_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CNT_W'(DEPTH));
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    head_o   = mem_q[rd_ptr_q];
    count_o  = count_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/xrv1_dmem_arb.sv
// Round-robin arbiter sharing one data-memory port between NUM_REQ_P
// requesters; responses are routed back in order via an outstanding-ID FIFO.
module xrv1_dmem_arb
  import xrv1_pkg::*;
#(
  parameter  int NUM_REQ_P        = 2,
  parameter  int OUTSTANDING_P    = 4,
  parameter  bit STRAY_RESP_CHK_P = 1'b1,
  localparam int REQ_ID_W_P       = $clog2(NUM_REQ_P)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ_P-1:0]    req_vld_i,
  output logic [NUM_REQ_P-1:0]    req_rdy_o,
  input  logic [NUM_REQ_P*32-1:0] req_addr_i,
  input  logic [NUM_REQ_P-1:0]    req_w_en_i,
  input  logic [NUM_REQ_P*4-1:0]  req_w_be_i,
  input  logic [NUM_REQ_P*32-1:0] req_w_data_i,
  output logic [NUM_REQ_P-1:0]    resp_vld_o,
  output logic                    resp_err_o,
  output logic [31:0]             resp_r_data_o,
  output logic                    dmem_req_vld_o,
  input  logic                    dmem_req_rdy_i,
  output logic [31:0]             dmem_req_addr_o,
  output logic                    dmem_req_w_en_o,
  output logic [3:0]              dmem_req_w_be_o,
  output logic [31:0]             dmem_req_w_data_o,
  input  logic                    dmem_resp_vld_i,
  input  logic                    dmem_resp_err_i,
  input  logic [31:0]             dmem_resp_r_data_i,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(OUTSTANDING_P) + 1;

  logic [REQ_ID_W_P-1:0] owner_q, owner_d;
  logic [REQ_ID_W_P-1:0] head_id, nxt_idx;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  own_vld, accept, pop, nxt_found;
  dmem_req_t             req_s [NUM_REQ_P];
  dmem_req_t             sel_req;

  // Returns {found, index} of the nearest valid requester after cur, cur itself excluded.
  function automatic logic [REQ_ID_W_P:0] rr_next(input logic [NUM_REQ_P-1:0]  vld,
                                                   input logic [REQ_ID_W_P-1:0] cur);
    logic [REQ_ID_W_P:0] res;
    int                  cand;
    res = '0;
    for (int k = NUM_REQ_P - 1; k >= 1; k--) begin
      cand = (int'(cur) + k) % NUM_REQ_P;
      if (vld[cand[REQ_ID_W_P-1:0]]) res = {1'b1, cand[REQ_ID_W_P-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ_P; i++) begin
      req_s[i].addr   = req_addr_i[32*i +: 32];
      req_s[i].w_en   = req_w_en_i[i];
      req_s[i].w_be   = req_w_be_i[4*i +: 4];
      req_s[i].w_data = req_w_data_i[32*i +: 32];
    end
  end

  // Request side: readiness comes only from registered owner/full and memory ready.
  always_comb begin
    // NOTE: every output gets a default before any conditional update, so no latch is inferred.
    req_rdy_o         = '0;
    sel_req           = req_s[owner_q];
    own_vld           = req_vld_i[owner_q];
    dmem_req_vld_o    = own_vld & ~fifo_full;
    dmem_req_addr_o   = sel_req.addr;
    dmem_req_w_en_o   = sel_req.w_en;
    dmem_req_w_be_o   = sel_req.w_be;
    dmem_req_w_data_o = sel_req.w_data;
    accept            = dmem_req_vld_o & dmem_req_rdy_i;
    if (dmem_req_rdy_i && !fifo_full) req_rdy_o = NUM_REQ_P'(1) << owner_q;
  end

  always_comb begin
    {nxt_found, nxt_idx} = rr_next(req_vld_i, owner_q);
    owner_d              = owner_q;
    if (nxt_found && (accept || !own_vld)) owner_d = nxt_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) owner_q <= '0;
    else       owner_q <= owner_d;
  end

  always_comb begin
    pop           = dmem_resp_vld_i & ~fifo_empty;
    resp_vld_o    = pop ? (NUM_REQ_P'(1) << head_id) : '0;
    resp_err_o    = dmem_resp_err_i;
    resp_r_data_o = dmem_resp_r_data_i;
    busy_o        = (fifo_count != '0);
  end

  xrv1_id_fifo #(
    .WIDTH (REQ_ID_W_P),
    .DEPTH (OUTSTANDING_P)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .push_data_i (owner_q),
    .pop_i       (pop),
    .head_o      (head_id),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // A response with nothing outstanding means the memory side broke its ordering contract.
  always_ff @(posedge clk_i) begin
    if (STRAY_RESP_CHK_P && !rst_i && dmem_resp_vld_i)
      assert (!fifo_empty) else $error("xrv1_dmem_arb: response with no outstanding request");
  end

endmodule

// File: tb/tb_xrv1_dmem_arb.sv
// Randomised and directed bench for xrv1_dmem_arb, checked every cycle
// against a queue-based model of ownership and outstanding IDs.
module tb_xrv1_dmem_arb;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_vld, req_rdy, req_w_en, resp_vld;
  logic [N*32-1:0] req_addr, req_w_data;
  logic [N*4-1:0] req_w_be;
  logic           resp_err, busy;
  logic [31:0]    resp_r_data;
  logic           dvld, drdy, dwen;
  logic [31:0]    daddr, dwdata;
  logic [3:0]     dbe;
  logic           mresp_vld, mresp_err;
  logic [31:0]    mresp_data;

  xrv1_dmem_arb #(
    .NUM_REQ_P        (N),
    .OUTSTANDING_P    (DEPTH),
    .STRAY_RESP_CHK_P (1'b0)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_vld_i          (req_vld),
    .req_rdy_o          (req_rdy),
    .req_addr_i         (req_addr),
    .req_w_en_i         (req_w_en),
    .req_w_be_i         (req_w_be),
    .req_w_data_i       (req_w_data),
    .resp_vld_o         (resp_vld),
    .resp_err_o         (resp_err),
    .resp_r_data_o      (resp_r_data),
    .dmem_req_vld_o     (dvld),
    .dmem_req_rdy_i     (drdy),
    .dmem_req_addr_o    (daddr),
    .dmem_req_w_en_o    (dwen),
    .dmem_req_w_be_o    (dbe),
    .dmem_req_w_data_o  (dwdata),
    .dmem_resp_vld_i    (mresp_vld),
    .dmem_resp_err_i    (mresp_err),
    .dmem_resp_r_data_i (mresp_data),
    .busy_o             (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: current owner and the requester IDs still awaiting a response.
  int          model_owner;
  int          id_q[$];
  int          auto_pct;
  logic [31:0] acc_addr_log[$];
  logic [N-1:0] resp_log[$];
  logic [31:0] resp_data_log[$];
  logic [N-1:0] last_rdy, last_resp;
  logic        last_dvld, last_err;

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] d);
    req_vld[i]           = v;
    req_addr[i*32 +: 32] = a;
    req_w_en[i]          = we;
    req_w_be[i*4 +: 4]   = be;
    req_w_data[i*32 +: 32] = d;
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic cycle();
    logic         full, e_dvld, acc, pop;
    logic [N-1:0] e_rdy, e_resp;
    int           nxt;
    if (auto_pct > 0) begin
      mresp_vld  = (id_q.size() > 0) && ($urandom_range(99) < auto_pct);
      mresp_err  = 1'($urandom_range(1));
      mresp_data = $urandom;
    end
    #1;
    full   = (id_q.size() == DEPTH);
    e_dvld = req_vld[model_owner] && !full;
    e_rdy  = (drdy && !full) ? (N'(1) << model_owner) : '0;
    acc    = e_dvld && drdy;
    pop    = mresp_vld && (id_q.size() > 0);
    e_resp = pop ? (N'(1) << id_q[0]) : '0;

    n_cmp++; if (req_rdy !== e_rdy) begin n_err++; $display("FAIL req_rdy: got %b want %b", req_rdy, e_rdy); end
    n_cmp++; if (dvld !== e_dvld) begin n_err++; $display("FAIL dmem_vld: got %b want %b", dvld, e_dvld); end
    if (e_dvld) begin
      n_cmp++;
      if ({daddr, dwen, dbe, dwdata} !== {req_addr[model_owner*32 +: 32], req_w_en[model_owner],
                                          req_w_be[model_owner*4 +: 4], req_w_data[model_owner*32 +: 32]}) begin
        n_err++;
        $display("FAIL dmem_fields: got %h/%b/%b/%h want %h/%b/%b/%h", daddr, dwen, dbe, dwdata,
                 req_addr[model_owner*32 +: 32], req_w_en[model_owner], req_w_be[model_owner*4 +: 4],
                 req_w_data[model_owner*32 +: 32]);
      end
    end
    n_cmp++; if (resp_vld !== e_resp) begin n_err++; $display("FAIL resp_vld: got %b want %b", resp_vld, e_resp); end
    n_cmp++; if ({resp_err, resp_r_data} !== {mresp_err, mresp_data}) begin
      n_err++; $display("FAIL resp_pass: got %b/%h want %b/%h", resp_err, resp_r_data, mresp_err, mresp_data);
    end
    n_cmp++; if (busy !== (id_q.size() != 0)) begin
      n_err++; $display("FAIL busy: got %b want %b", busy, id_q.size() != 0);
    end

    last_rdy = req_rdy; last_resp = resp_vld; last_dvld = dvld; last_err = resp_err;
    if (dvld && drdy) acc_addr_log.push_back(daddr);
    if (resp_vld != '0) begin resp_log.push_back(resp_vld); resp_data_log.push_back(resp_r_data); end

    @(posedge clk);
    if (pop) void'(id_q.pop_front());
    if (acc) id_q.push_back(model_owner);
    nxt = -1;
    for (int k = 1; k < N; k++) begin
      if (nxt < 0 && req_vld[(model_owner + k) % N]) nxt = (model_owner + k) % N;
    end
    if (nxt >= 0 && (acc || !req_vld[model_owner])) model_owner = nxt;
    @(negedge clk);
    mresp_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; mresp_vld = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_owner = 0;
    id_q.delete();
  endtask

  task automatic drain();
    int guard = 0;
    req_vld = '0; auto_pct = 100;
    while (id_q.size() > 0 && guard < 20) begin cycle(); guard++; end
    auto_pct = 0;
    n_cmp++; if (id_q.size() != 0) begin n_err++; $display("FAIL drain_timeout: left %0d want 0", id_q.size()); end
  endtask

  task automatic test_reset();
    drdy = 1'b1; do_reset(); #1;
    n_cmp++; if (req_rdy !== 2'b01) begin n_err++; $display("FAIL reset_rdy: got %b want 01", req_rdy); end
    n_cmp++; if (dvld !== 1'b0) begin n_err++; $display("FAIL reset_dvld: got %b want 0", dvld); end
    n_cmp++; if (resp_vld !== 2'b00) begin n_err++; $display("FAIL reset_resp: got %b want 00", resp_vld); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_single_reads();
    acc_addr_log.delete(); resp_log.delete(); resp_data_log.delete();
    drdy = 1'b1; auto_pct = 0;
    for (int c = 0; c < 5; c++) begin
      set_req(0, c < 3, 32'h100 + 32'(c * 4), 1'b0, 4'hf, 32'h0);
      set_req(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      if (c >= 1 && c <= 3) begin mresp_vld = 1'b1; mresp_err = 1'b0; mresp_data = 32'(32'h11 * c); end
      cycle();
    end
    n_cmp++; if (acc_addr_log.size() != 3) begin n_err++; $display("FAIL single_accepts: got %0d want 3", acc_addr_log.size()); end
    for (int k = 0; k < 3 && k < resp_log.size(); k++) begin
      n_cmp++;
      if (resp_log[k] !== 2'b01 || resp_data_log[k] !== 32'(32'h11 * (k + 1))) begin
        n_err++; $display("FAIL single_resp%0d: got %b/%h want 01/%h", k, resp_log[k], resp_data_log[k], 32'h11 * (k + 1));
      end
    end
    n_cmp++; if (resp_log.size() != 3) begin n_err++; $display("FAIL single_resp_count: got %0d want 3", resp_log.size()); end
  endtask

  task automatic test_alternate();
    do_reset();
    acc_addr_log.delete(); resp_log.delete(); resp_data_log.delete();
    drdy = 1'b1; auto_pct = 100;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 32'h0000_0000 + 32'(c * 4), 1'b0, 4'hf, 32'h0);
      set_req(1, 1'b1, 32'h0000_1000 + 32'(c * 4), 1'b0, 4'hf, 32'h0);
      cycle();
    end
    drain();
    n_cmp++; if (acc_addr_log.size() != 8) begin n_err++; $display("FAIL alt_accepts: got %0d want 8", acc_addr_log.size()); end
    for (int k = 0; k < 8 && k < acc_addr_log.size() && k < resp_log.size(); k++) begin
      n_cmp++;
      if (acc_addr_log[k][12] !== 1'(k % 2) || resp_log[k] !== (N'(1) << (k % 2))) begin
        n_err++; $display("FAIL alt_order%0d: got id %b strobe %b want id %0d", k, acc_addr_log[k][12], resp_log[k], k % 2);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    drdy = 1'b1; auto_pct = 0;
    set_req(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 32'h200 + 32'(c * 4), 1'b0, 4'hf, 32'h0);
      if (c == 6) begin mresp_vld = 1'b1; mresp_err = 1'b0; mresp_data = 32'hC0FFEE00; end
      cycle();
      if (c == 4 || c == 5) begin
        n_cmp++; if (last_rdy !== 2'b00 || last_dvld !== 1'b0) begin
          n_err++; $display("FAIL full_block: got rdy %b vld %b want 00/0", last_rdy, last_dvld);
        end
      end
      if (c == 6) begin
        n_cmp++; if (last_dvld !== 1'b0 || last_resp !== 2'b01) begin
          n_err++; $display("FAIL full_pop_same: got vld %b resp %b want 0/01", last_dvld, last_resp);
        end
      end
      if (c == 7) begin
        n_cmp++; if (last_dvld !== 1'b1 || last_rdy !== 2'b01) begin
          n_err++; $display("FAIL full_next: got vld %b rdy %b want 1/01", last_dvld, last_rdy);
        end
      end
    end
    drain();
  endtask

  task automatic test_bubble_stall();
    do_reset();
    drdy = 1'b1; auto_pct = 0;
    cycle();
    set_req(1, 1'b1, 32'h300, 1'b0, 4'hf, 32'h0);
    cycle();
    n_cmp++; if (last_dvld !== 1'b0 || last_rdy !== 2'b01) begin
      n_err++; $display("FAIL bubble_t: got vld %b rdy %b want 0/01", last_dvld, last_rdy);
    end
    cycle();
    n_cmp++; if (last_dvld !== 1'b1 || last_rdy !== 2'b10) begin
      n_err++; $display("FAIL bubble_t1: got vld %b rdy %b want 1/10", last_dvld, last_rdy);
    end
    set_req(1, 1'b1, 32'h304, 1'b1, 4'h3, 32'h5555_AAAA);
    drdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++; if (last_rdy !== 2'b00 || daddr !== 32'h304 || dwdata !== 32'h5555_AAAA) begin
        n_err++; $display("FAIL stall%0d: got rdy %b addr %h want 00/304", c, last_rdy, daddr);
      end
    end
    drdy = 1'b1;
    cycle();
    n_cmp++; if (last_rdy !== 2'b10) begin n_err++; $display("FAIL stall_owner: got %b want 10", last_rdy); end
    drain();
  endtask

  task automatic test_write_err();
    drdy = 1'b1; auto_pct = 0;
    set_req(1, 1'b1, 32'h0000_0400, 1'b1, 4'b0110, 32'hAABBCCDD);
    cycle();
    n_cmp++; if ({daddr, dwen, dbe, dwdata} !== {32'h400, 1'b1, 4'b0110, 32'hAABBCCDD}) begin
      n_err++; $display("FAIL write_fields: got %h/%b/%b/%h want 400/1/0110/aabbccdd", daddr, dwen, dbe, dwdata);
    end
    req_vld = '0; mresp_vld = 1'b1; mresp_err = 1'b1; mresp_data = 32'hDEAD0001;
    cycle();
    n_cmp++; if (last_resp !== 2'b10 || last_err !== 1'b1) begin
      n_err++; $display("FAIL write_resp: got %b/%b want 10/1", last_resp, last_err);
    end
    cycle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    drdy = 1'b1; auto_pct = 0;
    set_req(0, 1'b1, 32'h500, 1'b0, 4'hf, 32'h0);
    set_req(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    while (id_q.size() < 2 && guard < 10) begin cycle(); guard++; end
    n_cmp++; if (id_q.size() != 2) begin n_err++; $display("FAIL mid_fill: got %0d want 2", id_q.size()); end
    do_reset(); #1;
    n_cmp++; if (busy !== 1'b0 || req_rdy !== 2'b01) begin
      n_err++; $display("FAIL mid_reset: got busy %b rdy %b want 0/01", busy, req_rdy);
    end
    @(negedge clk);
    mresp_vld = 1'b1; mresp_err = 1'b0; mresp_data = 32'h57A7;
    cycle();
    n_cmp++; if (last_resp !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL stray: got resp %b busy %b want 00/0", last_resp, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    auto_pct = 50;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(1)), {$urandom, 2'b00} >> 2 << 2, 1'($urandom_range(1)),
                4'($urandom), $urandom);
      drdy = ($urandom_range(3) != 0);
      cycle();
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_addr = '0; req_w_en = '0; req_w_be = '0; req_w_data = '0;
    drdy = 1'b0; mresp_vld = 1'b0; mresp_err = 1'b0; mresp_data = '0;
    auto_pct = 0; model_owner = 0;
    test_reset();
    test_single_reads();
    test_alternate();
    test_full();
    test_bubble_stall();
    test_write_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
